mcycle_unit: RTL and testbench
==============================

# mcycle_unit

Parametrised multi-cycle multiply/divide unit that extends the processor's single-cycle ALU with MUL and DIV operations. The core raises Start with two operands. The unit iterates one bit per cycle, then returns a double-width product or a quotient/remainder pair. While Busy is high, the core stalls PC and register-file writes. The unit sits beside the ALU in the execute datapath; its results are muxed into Result.

## Interface
Parameters:
- WIDTH, 32, operand width in bits; legal values 4..64.

Ports:
- CLK  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  request; sampled only in IDLE
- MCycleOp  in  1  0 = multiply, 1 = divide
- Signed  in  1  1 = two's-complement operands, 0 = unsigned
- Operand1  in  WIDTH  multiplicand / dividend
- Operand2  in  WIDTH  multiplier / divisor
- Result1  out  WIDTH  product low half / quotient
- Result2  out  WIDTH  product high half / remainder
- Busy  out  1  operation in progress; registered
- Done  out  1  one-cycle pulse; results valid

## Operation
- States:
  - IDLE: Start=1 latches the operands, op and Signed, then goes to COMPUTE with count=0.
  - COMPUTE: one iteration per edge. After iteration WIDTH-1, goes to FIXUP.
  - FIXUP: applies sign correction, loads Result1/Result2, pulses Done and returns to IDLE.
- Signed mode:
  - Operands are converted to magnitudes at latch time.
  - Product sign is the XOR of the operand signs.
  - Quotient sign is the XOR of the operand signs; remainder sign follows the dividend.
- Multiply uses shift-add on a 2·WIDTH accumulator. Result2:Result1 holds the full 2·WIDTH product.
- Divide uses restoring division on a 2·WIDTH remainder/quotient register.
- Divide by zero: Result1 = all ones; Result2 = Operand1 as latched (raw, uncorrected). Latency is unchanged.
- Signed MIN / −1: Result1 = MIN, Result2 = 0. No flag is raised.
- Result1/Result2 hold their value until the next FIXUP. They do not change while Busy is high.
- Start while Busy=1 is ignored, and operands are not re-sampled.

## Timing
- Edge 0: samples Start. Busy goes to 1 after this edge.
- Edges 1..WIDTH: COMPUTE iterations.
- Edge WIDTH+1: FIXUP; Result registers load.
- After edge WIDTH+1:
  - Done=1 for exactly one cycle.
  - Busy=0.
  - Total latency is WIDTH+1 cycles from the Start-sampling edge.
- Done and IDLE coincide, so a Start during the Done cycle is accepted. Back-to-back issue gives one result every WIDTH+2 cycles.
- Reset low, at any time including mid-operation:
  - State goes to IDLE immediately.
  - Busy=0, Done=0, Result1=0, Result2=0, count=0.
  - The aborted operation never produces Done.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- MCYCLE_EARLY_TERM_EN
  - Defined: at each COMPUTE edge during a multiply, if the remaining multiplier bits are all zero, go straight to FIXUP. Minimum multiply latency is 2 cycles (multiplier 0 gives Done after edge 2). Divide timing is unaffected.
  - Undefined: all operations take exactly WIDTH+1 cycles; latency is fully deterministic.

## Structure
- Package mcycle_pkg holds:
  - state encoding: IDLE, COMPUTE, FIXUP
  - op encoding constants: OP_MUL=1'b0, OP_DIV=1'b1
  - localparam for counter width = $clog2(WIDTH)+1
- Sub-module mcycle_negate (combinational two's-complement with enable, width-parametrised). It is instanced for the operand-magnitude step and the result sign correction.
- FSM, counter and datapath registers live in mcycle_unit.

## Test plan
All cases use WIDTH=32.
- Unsigned multiply 0xFFFFFFFF × 0xFFFFFFFF: Result2=0xFFFFFFFE, Result1=0x00000001. Done at edge 33; Busy high edges 1–33.
- Signed multiply −3 × 7: Result2=0xFFFFFFFF, Result1=0xFFFFFFEB.
- Signed divide −7 ÷ 2: Result1=0xFFFFFFFD (−3), Result2=0xFFFFFFFF (−1). Unsigned 100 ÷ 7: Result1=14, Result2=2.
- Divide 100 ÷ 0: Result1=0xFFFFFFFF, Result2=100, Done at edge 33. Signed 0x80000000 ÷ −1: Result1=0x80000000, Result2=0.
- Start pulsed with new operands at edge 10 of a multiply: ignored, original product returned. Start held during the Done cycle: second op accepted, Done again after 33 more edges.
- Reset low at edge 15 of a divide: Busy/Done/Results are 0 immediately and no Done follows. Multiply 5 × 0 gives Done after edge 2 with MCYCLE_EARLY_TERM_EN, and after edge 33 without it.

Source files
------------

// File: rtl/mcycle_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
package mcycle_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    FIXUP   = 2'd2
  } mcycle_state_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Counter must hold WIDTH-1; one spare bit keeps the compare simple.
  function automatic int unsigned mcycle_cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/mcycle_negate.sv
// Combinational two's-complement negation, bypassed when the enable is low.
module mcycle_negate #(
  parameter int unsigned W = 32
) (
  input  logic         i_en,
  input  logic [W-1:0] i_a,
  output logic [W-1:0] o_y
);

  assign o_y = i_en ? ('0 - i_a) : i_a;

endmodule

// File: rtl/mcycle_unit.sv
// Multi-cycle shift-add multiplier / restoring divider, one bit per cycle.
// Optional MCYCLE_EARLY_TERM_EN: multiply finishes once remaining multiplier bits are zero.
module mcycle_unit
  import mcycle_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic             Signed,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CNT_W = mcycle_cnt_width(WIDTH);

  mcycle_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_count;
  logic                 r_op, r_neg1, r_neg2, r_dz;
  logic [WIDTH-1:0]     r_raw1;
  logic [2*WIDTH-1:0]   r_acc, r_mcand;
  logic [WIDTH-1:0]     r_opb;
  logic                 r_busy, r_done;
  logic [WIDTH-1:0]     r_res1, r_res2;

  logic                 w_load, w_iter, w_fix, w_last;
  logic [WIDTH-1:0]     w_mag1, w_mag2, w_opb_nxt, w_quo, w_rem;
  logic [2*WIDTH-1:0]   w_prod, w_div_nxt;
  logic [WIDTH:0]       w_rem_ext, w_diff;
  logic                 w_ge;

  mcycle_negate #(.W(WIDTH)) u_mag1 (
    .i_en (Signed & Operand1[WIDTH-1]),
    .i_a  (Operand1),
    .o_y  (w_mag1)
  );

  mcycle_negate #(.W(WIDTH)) u_mag2 (
    .i_en (Signed & Operand2[WIDTH-1]),
    .i_a  (Operand2),
    .o_y  (w_mag2)
  );

  mcycle_negate #(.W(2*WIDTH)) u_neg_prod (
    .i_en (r_neg1 ^ r_neg2),
    .i_a  (r_acc),
    .o_y  (w_prod)
  );

  mcycle_negate #(.W(WIDTH)) u_neg_quo (
    .i_en (r_neg1 ^ r_neg2),
    .i_a  (r_acc[WIDTH-1:0]),
    .o_y  (w_quo)
  );

  mcycle_negate #(.W(WIDTH)) u_neg_rem (
    .i_en (r_neg1),
    .i_a  (r_acc[2*WIDTH-1:WIDTH]),
    .o_y  (w_rem)
  );

  // Restoring step: partial remainder widened by one bit to catch the shifted-out MSB.
  assign w_rem_ext = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge      = (w_rem_ext >= {1'b0, r_opb});
  assign w_diff    = w_rem_ext - {1'b0, r_opb};
  assign w_div_nxt = w_ge ? {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                          : {r_acc[2*WIDTH-2:0], 1'b0};
  assign w_opb_nxt = r_opb >> 1;

`ifdef MCYCLE_EARLY_TERM_EN
  assign w_last = (r_count == CNT_W'(WIDTH - 1)) ||
                  ((r_op == OP_MUL) && (w_opb_nxt == '0));
`else
  assign w_last = (r_count == CNT_W'(WIDTH - 1));
`endif

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= w_fix;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_iter      = 1'b0;
    w_fix       = 1'b0;
    case (r_state)
      IDLE: begin
        if (Start) begin
          w_load      = 1'b1;
          w_state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        w_iter = 1'b1;
        if (w_last) w_state_nxt = FIXUP;
      end
      FIXUP: begin
        w_fix       = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_count <= '0;
      r_op    <= OP_MUL;
      r_neg1  <= 1'b0;
      r_neg2  <= 1'b0;
      r_dz    <= 1'b0;
      r_raw1  <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_opb   <= '0;
      r_res1  <= '0;
      r_res2  <= '0;
    end else if (w_load) begin
      r_count <= '0;
      r_op    <= MCycleOp;
      r_neg1  <= Signed & Operand1[WIDTH-1];
      r_neg2  <= Signed & Operand2[WIDTH-1];
      r_dz    <= (Operand2 == '0);
      r_raw1  <= Operand1;
      r_opb   <= w_mag2;
      if (MCycleOp == OP_MUL) begin
        r_acc   <= '0;
        r_mcand <= {{WIDTH{1'b0}}, w_mag1};
      end else begin
        r_acc   <= {{WIDTH{1'b0}}, w_mag1};
        r_mcand <= '0;
      end
    end else if (w_iter) begin
      r_count <= r_count + CNT_W'(1);
      if (r_op == OP_MUL) begin
        if (r_opb[0]) r_acc <= r_acc + r_mcand;
        r_mcand <= r_mcand << 1;
        r_opb   <= w_opb_nxt;
      end else begin
        r_acc <= w_div_nxt;
      end
    end else if (w_fix) begin
      if (r_op == OP_MUL) begin
        {r_res2, r_res1} <= w_prod;
      end else if (r_dz) begin
        r_res1 <= '1;
        r_res2 <= r_raw1;
      end else begin
        r_res1 <= w_quo;
        r_res2 <= w_rem;
      end
    end
  end

  assign Result1 = r_res1;
  assign Result2 = r_res2;
  assign Busy    = r_busy;
  assign Done    = r_done;

endmodule

// File: tb/tb_mcycle_unit.sv
// Directed self-checking bench for mcycle_unit at WIDTH=32.
module tb_mcycle_unit;
  import mcycle_pkg::*;

  logic        CLK      = 1'b0;
  logic        Reset    = 1'b0;
  logic        Start    = 1'b0;
  logic        MCycleOp = 1'b0;
  logic        Signed   = 1'b0;
  logic [31:0] Operand1 = '0;
  logic [31:0] Operand2 = '0;
  logic [31:0] Result1, Result2;
  logic        Busy, Done;

  int n_checks = 0;
  int n_fail   = 0;

  mcycle_unit #(.WIDTH(32)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .Start    (Start),
    .MCycleOp (MCycleOp),
    .Signed   (Signed),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Result1  (Result1),
    .Result2  (Result2),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected multiply latency given the multiplier magnitude.
  function automatic int mul_lat(input logic [31:0] m);
`ifdef MCYCLE_EARLY_TERM_EN
    int l = 2;
    for (int i = 0; i < 32; i++) if (m[i]) l = i + 2;
    return l;
`else
    return 33;
`endif
  endfunction

  task automatic issue(input logic op, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    MCycleOp = op;
    Signed   = sgn;
    Operand1 = a;
    Operand2 = b;
    Start    = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (Done !== 1'b1 && lat < 100) begin
      @(posedge CLK);
      #1;
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic op, input logic sgn,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] e1, input logic [31:0] e2, input int elat);
    int lat;
    issue(op, sgn, a, b);
    check_eq({tag, "_busy"}, Busy, 1);
    wait_done(lat);
    check_eq({tag, "_lat"}, lat, elat);
    check_eq({tag, "_r1"}, Result1, e1);
    check_eq({tag, "_r2"}, Result2, e2);
    check_eq({tag, "_idle"}, Busy, 0);
    @(posedge CLK);
    #1;
    check_eq({tag, "_pulse"}, Done, 0);
  endtask

  initial begin
    int lat;
    int n_done;

    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst_busy", Busy, 0);
    check_eq("rst_done", Done, 0);
    check_eq("rst_r1", Result1, 0);
    check_eq("rst_r2", Result2, 0);
    @(negedge CLK);
    Reset = 1'b1;

    run("umul_max", OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 33);
    run("smul", OP_MUL, 1'b1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF, mul_lat(32'd7));
    run("umul9", OP_MUL, 1'b0, 32'h1234_5678, 32'd9, 32'hA3D7_0A38, 32'h0, mul_lat(32'd9));
    run("sdiv_neg", OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    run("sdiv_negdiv", OP_DIV, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
    run("udiv", OP_DIV, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    run("udiv_big", OP_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);
    run("div0", OP_DIV, 1'b0, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, 33);
    run("sdiv0_raw", OP_DIV, 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 33);
    run("min_neg1", OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 33);
    run("mul_zero", OP_MUL, 1'b0, 32'd5, 32'd0, 32'h0, 32'h0, mul_lat(32'd0));
    run("umul9b", OP_MUL, 1'b0, 32'h1234_5678, 32'd9, 32'hA3D7_0A38, 32'h0, mul_lat(32'd9));

    // Start re-pulsed with new operands mid-multiply must be ignored.
    issue(OP_MUL, 1'b0, 32'd5, 32'h8000_0001);
    repeat (9) begin
      @(posedge CLK);
      #1;
    end
    check_eq("hold_r1", Result1, 32'hA3D7_0A38);
    MCycleOp = OP_DIV;
    Operand1 = 32'd100;
    Operand2 = 32'd100;
    Start    = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    check_eq("inj_busy", Busy, 1);
    wait_done(lat);
    check_eq("inj_lat", lat, 23);
    check_eq("inj_r1", Result1, 32'h8000_0005);
    check_eq("inj_r2", Result2, 32'h2);

    // Start presented during the Done cycle is accepted.
    issue(OP_DIV, 1'b0, 32'd100, 32'd7);
    wait_done(lat);
    check_eq("b2b_a_r1", Result1, 32'd14);
    MCycleOp = OP_MUL;
    Signed   = 1'b0;
    Operand1 = 32'd6;
    Operand2 = 32'd7;
    Start    = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    check_eq("b2b_busy", Busy, 1);
    check_eq("b2b_done_low", Done, 0);
    wait_done(lat);
    check_eq("b2b_lat", lat, mul_lat(32'd7));
    check_eq("b2b_r1", Result1, 32'd42);
    check_eq("b2b_r2", Result2, 32'd0);

    // Asynchronous reset in the middle of a divide.
    issue(OP_DIV, 1'b0, 32'd1000, 32'd3);
    repeat (14) @(posedge CLK);
    @(posedge CLK);
    #2;
    Reset = 1'b0;
    #1;
    check_eq("arst_busy", Busy, 0);
    check_eq("arst_done", Done, 0);
    check_eq("arst_r1", Result1, 0);
    check_eq("arst_r2", Result2, 0);
    #3;
    Reset = 1'b1;
    n_done = 0;
    repeat (40) begin
      @(posedge CLK);
      #1;
      if (Done) n_done++;
    end
    check_eq("arst_no_done", n_done, 0);
    check_eq("arst_idle", Busy, 0);
    run("post_rst", OP_DIV, 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 33);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
